crc_apb_feeder: RTL and testbench

Streaming front-end for the APB4 CRC peripheral. It accepts a byte stream (valid/ready with last), packs it into words of up to four bytes, and drives the CRC peripheral as an APB4 master. For multi-word messages it chains the intermediate CRC state through the INIT register, then reads back the final CRC. It sits directly upstream of the CRC peripheral, letting DMA or stream sources compute CRCs without CPU involvement.

---
 rtl/crc_apb_feeder.sv | 197 +++++++++++++++++++
 tb/tb_crc_apb_feeder.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_apb_feeder.sv
`timescale 1ns/1ps
// crc_apb_feeder: packs a byte stream into words of up to four bytes and drives an
// APB4 CRC peripheral, chaining intermediate state through INIT and reading back the CRC.
module crc_apb_feeder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned POLL_MAX  = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        start,
    input  logic [1:0]  cfg_mode,
    input  logic        cfg_revin,
    input  logic        cfg_revout,
    input  logic [31:0] cfg_init,
    input  logic [31:0] cfg_xorv,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] crc_o,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [2:0]  pprot,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FILL    = 4'd1;
    localparam logic [3:0] S_WR_CTRL = 4'd2;
    localparam logic [3:0] S_WR_INIT = 4'd3;
    localparam logic [3:0] S_WR_XORV = 4'd4;
    localparam logic [3:0] S_WR_DATA = 4'd5;
    localparam logic [3:0] S_RD_STAT = 4'd6;
    localparam logic [3:0] S_RD_DATA = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam int unsigned PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    logic [3:0]    r_state;
    logic          r_access;
    logic [31:0]   r_word;
    logic [2:0]    r_nbytes;
    logic          r_final;
    logic [31:0]   r_chain;
    logic [1:0]    r_mode;
    logic          r_revin;
    logic          r_revout;
    logic [31:0]   r_xorv;
    logic [PW-1:0] r_poll;
    logic          r_err;
    logic [31:0]   r_crc;

    logic          w_apb_active;
    logic          w_accept;
    logic [1:0]    w_size;
    logic [31:0]   w_ctrl;
    logic [7:0]    w_offset;
    logic          w_write;
    logic [31:0]   w_wdata;

    assign w_apb_active = (r_state >= S_WR_CTRL) && (r_state <= S_RD_DATA);
    assign s_ready      = (r_state == S_FILL) && (r_nbytes < 3'd4);
    assign w_accept     = s_valid && s_ready;
    assign w_size       = r_nbytes[1:0] - 2'd1;
    // Intermediate words leave output reflection and XOR off so DATA returns the raw state.
    assign w_ctrl       = {25'b0, w_size, r_mode, r_final & r_revout, r_revin, 1'b1};

    always_comb begin
        w_offset = 8'h00;
        w_write  = 1'b0;
        w_wdata  = '0;
        case (r_state)
            S_WR_CTRL: begin w_offset = 8'h00; w_write = 1'b1; w_wdata = w_ctrl;  end
            S_WR_INIT: begin w_offset = 8'h04; w_write = 1'b1; w_wdata = r_chain; end
            S_WR_XORV: begin w_offset = 8'h08; w_write = 1'b1; w_wdata = r_final ? r_xorv : '0; end
            S_WR_DATA: begin w_offset = 8'h0C; w_write = 1'b1; w_wdata = r_word;  end
            S_RD_STAT: begin w_offset = 8'h10; end
            S_RD_DATA: begin w_offset = 8'h0C; end
            default:   begin w_offset = 8'h00; end
        endcase
    end

    assign psel    = w_apb_active;
    assign penable = r_access;
    assign pwrite  = w_apb_active & w_write;
    assign paddr   = w_apb_active ? (BASE_ADDR + {24'b0, w_offset}) : '0;
    assign pwdata  = w_apb_active ? w_wdata : '0;
    assign pstrb   = (w_apb_active && w_write) ? 4'hF : 4'h0;
    assign pprot   = 3'b000;

    assign busy  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done  = (r_state == S_DONE);
    assign err   = r_err;
    assign crc_o = r_crc;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state  <= S_IDLE;
            r_access <= 1'b0;
            r_word   <= '0;
            r_nbytes <= '0;
            r_final  <= 1'b0;
            r_chain  <= '0;
            r_mode   <= '0;
            r_revin  <= 1'b0;
            r_revout <= 1'b0;
            r_xorv   <= '0;
            r_poll   <= '0;
            r_err    <= 1'b0;
            r_crc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode   <= cfg_mode;
                        r_revin  <= cfg_revin;
                        r_revout <= cfg_revout;
                        r_xorv   <= cfg_xorv;
                        r_chain  <= cfg_init;
                        r_err    <= 1'b0;
                        r_poll   <= '0;
                        r_word   <= '0;
                        r_nbytes <= '0;
                        r_final  <= 1'b0;
                        r_state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_word   <= {r_word[23:0], s_data};
                        r_nbytes <= r_nbytes + 3'd1;
                        if (s_last || (r_nbytes == 3'd3)) begin
                            r_final  <= s_last;
                            r_access <= 1'b0;
                            r_state  <= S_WR_CTRL;
                        end
                    end
                end
                S_WR_CTRL, S_WR_INIT, S_WR_XORV, S_WR_DATA, S_RD_STAT, S_RD_DATA: begin
                    if (!r_access) begin
                        r_access <= 1'b1;
                    end else if (pready) begin
                        r_access <= 1'b0;
                        if (pslverr) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            case (r_state)
                                S_WR_CTRL: r_state <= S_WR_INIT;
                                S_WR_INIT: r_state <= S_WR_XORV;
                                S_WR_XORV: r_state <= S_WR_DATA;
                                S_WR_DATA: begin
                                    r_poll  <= '0;
                                    r_state <= S_RD_STAT;
                                end
                                S_RD_STAT: begin
                                    if (prdata[0]) begin
                                        r_state <= S_RD_DATA;
                                    end else if (r_poll == POLL_LAST) begin
                                        r_err   <= 1'b1;
                                        r_state <= S_DONE;
                                    end else begin
                                        r_poll <= r_poll + 1'b1;
                                    end
                                end
                                default: begin
                                    if (r_final) begin
                                        r_crc   <= prdata;
                                        r_state <= S_DONE;
                                    end else begin
                                        r_chain  <= prdata;
                                        r_word   <= '0;
                                        r_nbytes <= '0;
                                        r_state  <= S_FILL;
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_apb_feeder.sv
`timescale 1ns/1ps
// Bench for crc_apb_feeder: behavioural APB CRC peripheral plus scoreboards of expected
// APB writes and final CRCs, exercised by one task per scenario.
module tb_crc_apb_feeder;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int unsigned PMAX = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } xfer_t;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        start;
    logic [1:0]  cfg_mode;
    logic        cfg_revin;
    logic        cfg_revout;
    logic [31:0] cfg_init;
    logic [31:0] cfg_xorv;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] crc_o;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    int          n_wait = 0;
    bit          stat_never = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int          wcnt = 0;
    int          stat_cnt = 0;
    logic [31:0] s_ctrl = '0, s_init = '0, s_xorv = '0, s_res = '0;

    logic [31:0] su_addr = '0, su_wdata = '0;
    logic        su_write = 1'b0;
    bit          unstable = 1'b0;
    int          n_stat = 0;
    int          n_done = 0;
    xfer_t       obs_wr[$];
    logic [31:0] obs_rd[$];
    xfer_t       exp_wr[$];
    logic [31:0] exp_crc[$];

    always #5 pclk = ~pclk;

    crc_apb_feeder #(
        .BASE_ADDR (BASE),
        .POLL_MAX  (PMAX)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .start      (start),
        .cfg_mode   (cfg_mode),
        .cfg_revin  (cfg_revin),
        .cfg_revout (cfg_revout),
        .cfg_init   (cfg_init),
        .cfg_xorv   (cfg_xorv),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .crc_o      (crc_o),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pprot      (pprot),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    // Peripheral model: modes 0/1/2 = CRC-8/07, CRC-16/1021, CRC-32/04C11DB7, MSB-first register.
    function automatic logic [31:0] crc_periph(input logic [31:0] c, input logic [31:0] ini,
                                               input logic [31:0] xv, input logic [31:0] d);
        int unsigned w;
        int          nb;
        logic [31:0] poly, mask, st, r;
        logic [7:0]  b, rb;
        logic        fb;
        case (c[4:3])
            2'd0:    begin w = 8;  poly = 32'h07;        end
            2'd1:    begin w = 16; poly = 32'h1021;      end
            default: begin w = 32; poly = 32'h04C11DB7;  end
        endcase
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        nb   = int'(c[6:5]) + 1;
        st   = ini & mask;
        for (int i = nb - 1; i >= 0; i--) begin
            b = d[8*i +: 8];
            if (c[1]) begin
                for (int k = 0; k < 8; k++) rb[k] = b[7-k];
                b = rb;
            end
            for (int k = 7; k >= 0; k--) begin
                fb = st[w-1] ^ b[k];
                st = (st << 1) & mask;
                if (fb) st = st ^ poly;
            end
        end
        if (c[2]) begin
            r = '0;
            for (int k = 0; k < int'(w); k++) r[k] = st[int'(w)-1-k];
            st = r;
        end
        return (st ^ xv) & mask;
    endfunction

    assign pready  = psel && penable && (wcnt >= n_wait);
    assign pslverr = pready && err_en && (paddr == err_addr);
    assign prdata  = !psel ? 32'h0 :
                     (paddr == BASE + 32'h10) ? {31'b0, (!stat_never && stat_cnt >= 1)} :
                     (paddr == BASE + 32'h0C) ? s_res : 32'h0;

    always @(posedge pclk) begin
        if (psel && penable) begin
            if (!pready) begin
                wcnt <= wcnt + 1;
            end else begin
                wcnt <= 0;
                if (pwrite && !pslverr) begin
                    if (paddr == BASE)                 s_ctrl <= pwdata;
                    else if (paddr == BASE + 32'h04)   s_init <= pwdata;
                    else if (paddr == BASE + 32'h08)   s_xorv <= pwdata;
                    else if (paddr == BASE + 32'h0C) begin
                        s_res    <= crc_periph(s_ctrl, s_init, s_xorv, pwdata);
                        stat_cnt <= 0;
                    end
                end else if (!pwrite && paddr == BASE + 32'h10) begin
                    stat_cnt <= stat_cnt + 1;
                end
            end
        end else begin
            wcnt <= 0;
        end
    end

    always @(negedge pclk) begin
        if (psel && !penable) begin
            su_addr  <= paddr;
            su_wdata <= pwdata;
            su_write <= pwrite;
        end
        if (psel && penable) begin
            if (paddr !== su_addr || pwdata !== su_wdata || pwrite !== su_write) unstable <= 1'b1;
            if (!pwrite && pstrb !== 4'h0) unstable <= 1'b1;
            if (pready) begin
                if (pwrite) obs_wr.push_back('{paddr, pwdata, pstrb});
                else if (paddr == BASE + 32'h0C) obs_rd.push_back(prdata);
                else if (paddr == BASE + 32'h10) n_stat <= n_stat + 1;
            end
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic do_start(input logic [1:0] m, input logic ri, input logic ro,
                            input logic [31:0] ini, input logic [31:0] xv);
        cfg_mode = m; cfg_revin = ri; cfg_revout = ro; cfg_init = ini; cfg_xorv = xv;
        start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        // Scramble configuration while busy; the latched copy must be used.
        cfg_mode = ~m; cfg_revin = ~ri; cfg_revout = ~ro; cfg_init = ~ini; cfg_xorv = 32'h1234_5678;
    endtask

    task automatic send_bytes(input string msg, input bit with_last, input bit toggle, output bit ok);
        bit got;
        ok = 1'b1;
        for (int i = 0; i < msg.len(); i++) begin
            if (toggle) begin
                s_valid = 1'b0;
                @(posedge pclk); #1;
            end
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = with_last && (i == msg.len() - 1);
            got = 1'b0;
            for (int t = 0; t < 2000 && !got; t++) begin
                @(negedge pclk);
                if (s_ready) begin
                    @(posedge pclk); #1;
                    got = 1'b1;
                end
            end
            if (!got) begin
                ok = 1'b0;
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int t = 1; t <= 5000; t++) begin
            @(negedge pclk);
            if (done) begin
                cyc = t;
                break;
            end
        end
    endtask

    task automatic test_reset;
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, pstrb, pprot} !== 9'b0 || paddr !== 32'h0 || pwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_apb: psel=%b penable=%b pwrite=%b pstrb=%h paddr=%h pwdata=%h, required all 0",
                     psel, penable, pwrite, pstrb, paddr, pwdata);
        end
        checks++;
        if ({s_ready, busy, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_status: s_ready=%b busy=%b done=%b err=%b, required 0000", s_ready, busy, done, err);
        end
        checks++;
        if (crc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_crc: crc_o=%h required 00000000", crc_o);
        end
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_crc_vectors;
        string       vmsg[3];
        logic [1:0]  vmode[3];
        logic        vri[3], vro[3];
        logic [31:0] vini[3], vxv[3], vexp[3];
        logic [31:0] chain, w, ctrl, want, rd_first, rd_last;
        logic [1:0]  nbm1;
        int          nb, cyc, d0, idx;
        bit          ok, fin;
        xfer_t       o, e;
        xfer_t       snap[$];
        vmsg[0] = "123456789"; vmode[0] = 2'd2; vri[0] = 1; vro[0] = 1; vini[0] = 32'hFFFF_FFFF; vxv[0] = 32'hFFFF_FFFF; vexp[0] = 32'hCBF4_3926;
        vmsg[1] = "123456789"; vmode[1] = 2'd1; vri[1] = 0; vro[1] = 0; vini[1] = 32'h0000_FFFF; vxv[1] = 32'h0;         vexp[1] = 32'h0000_29B1;
        vmsg[2] = "1";         vmode[2] = 2'd0; vri[2] = 0; vro[2] = 0; vini[2] = 32'h0;         vxv[2] = 32'h0;         vexp[2] = 32'h0000_0097;
        for (int wm = 0; wm < 2; wm++) begin
            n_wait = (wm == 1) ? 3 : 0;
            for (int v = 0; v < 3; v++) begin
                exp_wr.delete(); obs_wr.delete(); obs_rd.delete();
                chain = vini[v]; w = '0; nb = 0;
                for (int i = 0; i < vmsg[v].len(); i++) begin
                    w = {w[23:0], vmsg[v][i]};
                    nb++;
                    if (nb == 4 || i == vmsg[v].len() - 1) begin
                        fin  = (i == vmsg[v].len() - 1);
                        nbm1 = 2'(nb - 1);
                        ctrl = {25'b0, nbm1, vmode[v], fin ? vro[v] : 1'b0, vri[v], 1'b1};
                        exp_wr.push_back('{BASE,            ctrl,                  4'hF});
                        exp_wr.push_back('{BASE + 32'h04,   chain,                 4'hF});
                        exp_wr.push_back('{BASE + 32'h08,   fin ? vxv[v] : 32'h0,  4'hF});
                        exp_wr.push_back('{BASE + 32'h0C,   w,                     4'hF});
                        if (!fin) chain = crc_periph(ctrl, chain, 32'h0, w);
                        w = '0; nb = 0;
                    end
                end
                exp_crc.push_back(vexp[v]);
                d0 = n_done;
                do_start(vmode[v], vri[v], vro[v], vini[v], vxv[v]);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_start w%0d v%0d: busy=%b required 1", wm, v, busy);
                end
                send_bytes(vmsg[v], 1'b1, wm == 1, ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL stream_accept w%0d v%0d: byte not accepted within bound", wm, v);
                end
                wait_done(cyc);
                want = exp_crc.pop_front();
                checks++;
                if (cyc < 0) begin
                    errors++;
                    $display("FAIL done_timeout w%0d v%0d: no done pulse within bound", wm, v);
                end
                checks++;
                if (crc_o !== want || err !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL crc_result w%0d v%0d: crc_o=%h err=%b busy=%b, required crc_o=%h err=0 busy=0",
                             wm, v, crc_o, err, busy, want);
                end
                @(negedge pclk);
                checks++;
                if (n_done - d0 !== 1) begin
                    errors++;
                    $display("FAIL done_count w%0d v%0d: %0d pulses, required 1", wm, v, n_done - d0);
                end
                snap = obs_wr;
                rd_first = (obs_rd.size() > 0) ? obs_rd[0] : 32'hx;
                rd_last  = (obs_rd.size() > 0) ? obs_rd[obs_rd.size()-1] : 32'hx;
                idx = 0;
                while (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    checks++;
                    if (obs_wr.size() == 0) begin
                        errors++;
                        $display("FAIL apb_write w%0d v%0d #%0d: missing, required addr=%h data=%h", wm, v, idx, e.addr, e.data);
                    end else begin
                        o = obs_wr.pop_front();
                        if (o.addr !== e.addr || o.data !== e.data || o.strb !== e.strb) begin
                            errors++;
                            $display("FAIL apb_write w%0d v%0d #%0d: addr=%h data=%h strb=%h, required addr=%h data=%h strb=%h",
                                     wm, v, idx, o.addr, o.data, o.strb, e.addr, e.data, e.strb);
                        end
                    end
                    idx++;
                end
                checks++;
                if (obs_wr.size() != 0) begin
                    errors++;
                    $display("FAIL apb_extra_writes w%0d v%0d: %0d extra, required 0", wm, v, obs_wr.size());
                end
                if (v == 0) begin
                    checks++;
                    if (snap.size() < 9 || snap[8].data[6:5] !== 2'd0 || snap[8].data[2] !== 1'b1) begin
                        errors++;
                        $display("FAIL last_ctrl w%0d: ctrl=%h, required size=0 revout=1",
                                 wm, (snap.size() >= 9) ? snap[8].data : 32'hx);
                    end
                end
                if (v == 1) begin
                    checks++;
                    if (snap.size() < 6 || snap[5].data !== rd_first) begin
                        errors++;
                        $display("FAIL init_chain w%0d: second INIT=%h, required first DATA readback %h",
                                 wm, (snap.size() >= 6) ? snap[5].data : 32'hx, rd_first);
                    end
                end
                if (v == 2) begin
                    checks++;
                    if (crc_o !== rd_last) begin
                        errors++;
                        $display("FAIL crc_readback w%0d: crc_o=%h, required DATA readback %h", wm, crc_o, rd_last);
                    end
                end
                checks++;
                if (unstable) begin
                    errors++;
                    $display("FAIL apb_stable w%0d v%0d: unstable=1 required 0", wm, v);
                end
            end
        end
        n_wait = 0;
    endtask

    task automatic test_latency;
        int  cyc;
        bit  ok;
        n_wait = 0;
        do_start(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        send_bytes("1", 1'b1, 1'b0, ok);
        wait_done(cyc);
        checks++;
        if (!ok || cyc != 15) begin
            errors++;
            $display("FAIL back_to_back_latency: ok=%0d done after %0d cycles, required 15", ok, cyc);
        end
        @(negedge pclk);
    endtask

    task automatic test_poll_timeout;
        logic [31:0] prev;
        int          s0, d0, cyc;
        bit          ok;
        prev = crc_o; s0 = n_stat; d0 = n_done;
        stat_never = 1'b1;
        do_start(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        send_bytes("1", 1'b1, 1'b0, ok);
        wait_done(cyc);
        checks++;
        if (cyc < 0 || err !== 1'b1 || crc_o !== prev) begin
            errors++;
            $display("FAIL poll_timeout: cyc=%0d err=%b crc_o=%h, required done err=1 crc_o=%h", cyc, err, crc_o, prev);
        end
        @(negedge pclk);
        checks++;
        if (n_stat - s0 != int'(PMAX) || n_done - d0 != 1) begin
            errors++;
            $display("FAIL poll_count: stat reads=%0d done pulses=%0d, required %0d and 1", n_stat - s0, n_done - d0, PMAX);
        end
        stat_never = 1'b0;
    endtask

    task automatic test_slverr;
        logic [31:0] prev;
        int          cyc;
        bit          ok;
        prev = crc_o;
        obs_wr.delete();
        err_en = 1'b1; err_addr = BASE + 32'h04;
        do_start(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        send_bytes("1", 1'b1, 1'b0, ok);
        wait_done(cyc);
        checks++;
        if (cyc < 0 || err !== 1'b1 || crc_o !== prev) begin
            errors++;
            $display("FAIL slverr_abort: cyc=%0d err=%b crc_o=%h, required done err=1 crc_o=%h", cyc, err, crc_o, prev);
        end
        @(negedge pclk);
        checks++;
        if (obs_wr.size() != 2) begin
            errors++;
            $display("FAIL slverr_writes: %0d writes, required 2", obs_wr.size());
        end
        err_en = 1'b0;
    endtask

    task automatic test_reset_mid_transfer;
        int  cyc;
        bit  ok, hit;
        do_start(2'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_start: err=%b required 0", err);
        end
        n_wait = 3;
        send_bytes("1234", 1'b0, 1'b0, ok);
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge pclk);
            if (psel && penable && pwrite && paddr == BASE + 32'h0C) hit = 1'b1;
        end
        checks++;
        if (!ok || !hit) begin
            errors++;
            $display("FAIL reach_wr_data: ok=%0d hit=%0d, required 1 1", ok, hit);
        end
        #2 presetn = 1'b0;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: psel=%b penable=%b busy=%b s_ready=%b, required 0000", psel, penable, busy, s_ready);
        end
        @(posedge pclk); #1;
        presetn = 1'b1;
        n_wait = 0;
        exp_crc.push_back(32'hCBF4_3926);
        do_start(2'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_bytes("123456789", 1'b1, 1'b0, ok);
        wait_done(cyc);
        checks++;
        if (!ok || cyc < 0 || crc_o !== exp_crc[0] || err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_msg: ok=%0d cyc=%0d crc_o=%h err=%b, required crc_o=%h err=0",
                     ok, cyc, crc_o, err, exp_crc[0]);
        end
        void'(exp_crc.pop_front());
        @(negedge pclk);
    endtask

    initial begin
        start = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0;
        cfg_mode = 2'd0; cfg_revin = 1'b0; cfg_revout = 1'b0; cfg_init = '0; cfg_xorv = '0;
        presetn = 1'b0;
        test_reset;
        test_crc_vectors;
        test_latency;
        test_poll_timeout;
        test_slverr;
        test_reset_mid_transfer;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
